// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay_sched shared-timer scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // Counter preload so that an up-count reaches all-ones after max(d,1)-1 steps.
  // The result is modulo 2^32; callers truncate it to their WIDTH (WIDTH <= 32).
  function automatic logic [31:0] load_value(input logic [31:0] d);
    logic [31:0] d_eff;
    d_eff = (d == 32'd0) ? 32'd1 : d;
    return 32'd0 - d_eff;
  endfunction

endpackage

// File: rtl/delay_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclically.
module delay_sched_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  // Scan N positions starting at ptr_i; the first hit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Shared-timer scheduler: round-robin grant, single loadable up-counter, done pulse per owner.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*WIDTH-1:0] delay,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic             busy,
  output logic [IDXW-1:0]  owner,
  output logic [WIDTH-1:0] cnt
);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic [IDXW-1:0]  arb_idx;
  logic             arb_valid;

  delay_sched_rr_arb #(
    .N(N)
  ) u_rr_arb (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  // Next-state: arbitrate in idle, preload, count to all-ones, pulse done, advance pointer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    delay_d  = delay_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          // Delay is captured only here; later changes to the input are ignored.
          delay_d = delay[WIDTH*int'(arb_idx) +: WIDTH];
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = WIDTH'(load_value(32'(delay_q)));
        state_d = StRun;
      end
      StRun: begin
        // Terminal count holds the counter; no wrap past all-ones.
        if (cnt_q == '1) state_d = StDone;
        else             cnt_d   = cnt_q + WIDTH'(1);
      end
      StDone: begin
        rr_ptr_d = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + IDXW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      delay_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      delay_q  <= delay_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from state and owner; grant spans LOAD through DONE.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q != StIdle) gnt[owner_q] = 1'b1;
    if (state_q == StDone) done[owner_q] = 1'b1;
  end

  assign busy  = (state_q != StIdle);
  assign owner = owner_q;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: single-job table plus contention, mid-job, fairness, reset.
module tb_delay_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     owner;
  logic [W-1:0]   cnt;

  int checks;
  int errors;

  delay_sched #(
    .N(N),
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .delay(delay),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .owner(owner),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] dly;      // {D3, D2, D1, D0}
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_owner;
    logic [15:0] exp_load;
    int          deff;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated job from idle; req is dropped right after the grant edge.
  task automatic run_job(input vec_t v, input int k);
    int  n;
    bit  got;
    req   = v.req;
    delay = v.dly;
    tick();
    check($sformatf("v%0d_gnt", k), gnt, v.exp_gnt);
    check($sformatf("v%0d_busy", k), busy, 1);
    check($sformatf("v%0d_owner", k), owner, v.exp_owner);
    req = '0;
    tick();
    check($sformatf("v%0d_load", k), cnt, v.exp_load);
    n   = 1;
    got = 0;
    while (n < v.deff + 6 && !got) begin
      tick();
      n++;
      if (done != '0) got = 1;
    end
    check($sformatf("v%0d_latency", k), n, v.deff + 1);
    check($sformatf("v%0d_done", k), done, v.exp_gnt);
    check($sformatf("v%0d_cnt_term", k), cnt, 16'hFFFF);
    tick();
    check($sformatf("v%0d_done_drop", k), done, 0);
    check($sformatf("v%0d_idle", k), busy, 0);
  endtask

  initial begin
    bit seen;
    checks = 0;
    errors = 0;

    // rr_ptr progression is tracked by hand in the expected owners.
    vecs[0] = '{4'b0100, {16'd0, 16'd5, 16'd0, 16'd0},  4'b0100, 2'd2, 16'hFFFB, 5};
    vecs[1] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd0},  4'b0001, 2'd0, 16'hFFFF, 1};
    vecs[2] = '{4'b0010, {16'd0, 16'd0, 16'd1, 16'd0},  4'b0010, 2'd1, 16'hFFFF, 1};
    vecs[3] = '{4'b1001, {16'd2, 16'd0, 16'd0, 16'd7},  4'b1000, 2'd3, 16'hFFFE, 2};
    vecs[4] = '{4'b1001, {16'd2, 16'd0, 16'd0, 16'd7},  4'b0001, 2'd0, 16'hFFF9, 7};
    vecs[5] = '{4'b0101, {16'd0, 16'd10, 16'd0, 16'd3}, 4'b0100, 2'd2, 16'hFFF6, 10};
    vecs[6] = '{4'b0011, {16'd0, 16'd0, 16'd4, 16'd4},  4'b0001, 2'd0, 16'hFFFC, 4};
    vecs[7] = '{4'b1000, {16'hFFFF, 16'd0, 16'd0, 16'd0}, 4'b1000, 2'd3, 16'h0001, 65535};

    rst_n = 1'b0;
    req   = '0;
    delay = '0;
    repeat (2) tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_stay_idle", busy, 0);

    for (int k = 0; k < 8; k++) run_job(vecs[k], k);

    // Contention: all request with D=3, rr_ptr = 0 -> 0,1,2,3,0 with 6-edge spacing.
    req   = 4'hF;
    delay = {4{16'd3}};
    for (int j = 0; j < 5; j++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (j % 4);
      tick();
      check($sformatf("cont%0d_gnt", j), gnt, eg);
      if (j == 4) req = '0;
      repeat (3) tick();
      check($sformatf("cont%0d_early", j), done, 0);
      tick();
      check($sformatf("cont%0d_done", j), done, eg);
      tick();
      check($sformatf("cont%0d_gap", j), gnt, 0);
    end

    // Mid-job changes are ignored; rr_ptr = 1.
    req   = 4'b0010;
    delay = {16'd0, 16'd0, 16'd4, 16'd0};
    tick();
    check("mid_gnt", gnt, 4'b0010);
    repeat (2) tick();
    delay[31:16] = 16'd100;
    req          = '0;
    repeat (2) tick();
    check("mid_early", done, 0);
    tick();
    check("mid_done", done, 4'b0010);
    tick();
    check("mid_idle", busy, 0);

    // Late arrival beats a continuously held re-requester; rr_ptr = 2.
    req   = 4'b1000;
    delay = {16'd3, 16'd0, 16'd2, 16'd0};
    tick();
    check("fair_first", gnt, 4'b1000);
    req = 4'b1010;
    repeat (5) tick();
    check("fair_gap", gnt, 0);
    tick();
    check("fair_gnt", gnt, 4'b0010);
    req = '0;
    repeat (4) tick();
    check("fair_idle", busy, 0);

    // Reset mid-RUN aborts without a done pulse and clears rr_ptr (currently 2).
    req   = 4'b0001;
    delay = {16'd0, 16'd0, 16'd0, 16'd20};
    tick();
    req = '0;
    repeat (4) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    check("arst_owner", owner, 0);
    check("arst_cnt", cnt, 0);
    seen = 0;
    repeat (25) begin
      tick();
      if (done != '0) seen = 1;
    end
    check("arst_no_done", seen, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", busy, 0);
    req   = 4'b0011;
    delay = {16'd0, 16'd0, 16'd1, 16'd1};
    tick();
    check("post_rst_owner", owner, 0);
    check("post_rst_gnt", gnt, 4'b0001);
    req = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
